// File: rtl/me_ctrl_search_unit.sv
// Full-search motion estimation control: address/PE enables, SAD minimum tracking.
// Optional macro TIEBREAK_CENTER_EN: on equal SAD prefer the vector closest to the window centre.
module me_ctrl_search_unit #(
  parameter  int SAD_WIDTH  = 16,
  parameter  int TB_LENGTH  = 16,
  parameter  int SW_LENGTH  = 64,
  parameter  int PE_LATENCY = 55,
  parameter  int CNT_WIDTH  = 12,
  localparam int MV_WIDTH   = $clog2(SW_LENGTH - TB_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  abort,
  input  logic                  thr_en,
  input  logic [SAD_WIDTH-1:0]  sad_thresh,
  input  logic [SAD_WIDTH-1:0]  sad,
  output logic                  clr,
  output logic                  en_addr_sw,
  output logic                  en_addr_tb,
  output logic                  en_pearray_sw,
  output logic                  en_pearray_tb,
  output logic [SAD_WIDTH-1:0]  min_sad,
  output logic [2*MV_WIDTH-1:0] min_mvec,
  output logic [CNT_WIDTH-1:0]  cand_cnt,
  output logic                  early_term,
  output logic                  aborted,
  output logic                  ack
);

  localparam int CYC_W = $clog2(PE_LATENCY + SW_LENGTH * SW_LENGTH + 1);
  localparam int XY_W  = $clog2(SW_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CYC_W-1:0]    cyc_q;
  logic [XY_W-1:0]     x_q, y_q;
  logic                pe_sw_q, pe_tb_q;
  logic                run;
  logic                scan_act;
  logic                cand_vld;
  logic                scan_end;
  logic                thr_hit;
  logic                better;
  logic [MV_WIDTH-1:0] x_off, y_off;

  assign run      = (state_q == S_RUN);
  assign scan_act = run && (cyc_q >= CYC_W'(PE_LATENCY));
  assign cand_vld = scan_act
                 && (x_q >= XY_W'(TB_LENGTH - 1))
                 && (y_q >= XY_W'(TB_LENGTH - 1));
  assign scan_end = scan_act
                 && (x_q == XY_W'(SW_LENGTH - 1))
                 && (y_q == XY_W'(SW_LENGTH - 1));
  assign thr_hit  = cand_vld && thr_en && (sad <= sad_thresh);

  // Offsets are small enough that modular arithmetic in MV_WIDTH bits is exact
  assign x_off = MV_WIDTH'(x_q) - MV_WIDTH'(TB_LENGTH - 1);
  assign y_off = MV_WIDTH'(y_q) - MV_WIDTH'(TB_LENGTH - 1);

  assign clr           = (state_q == S_IDLE);
  assign ack           = (state_q == S_DONE);
  assign en_addr_sw    = run && (cyc_q < CYC_W'(SW_LENGTH * SW_LENGTH));
  assign en_addr_tb    = run && (cyc_q < CYC_W'(TB_LENGTH * TB_LENGTH));
  assign en_pearray_sw = run && pe_sw_q;
  assign en_pearray_tb = run && pe_tb_q;

`ifdef TIEBREAK_CENTER_EN
  localparam int C_OFF = (SW_LENGTH - TB_LENGTH) / 2;

  logic [MV_WIDTH:0]   dist_q, dist_d;
  logic [MV_WIDTH-1:0] dx, dy;

  assign dx = (x_off >= MV_WIDTH'(C_OFF)) ? x_off - MV_WIDTH'(C_OFF)
                                          : MV_WIDTH'(C_OFF) - x_off;
  assign dy = (y_off >= MV_WIDTH'(C_OFF)) ? y_off - MV_WIDTH'(C_OFF)
                                          : MV_WIDTH'(C_OFF) - y_off;
  assign dist_d = {1'b0, dx} + {1'b0, dy};
  assign better = (sad < min_sad)
               || ((sad == min_sad) && (dist_d < dist_q));

  // Centre distance of the stored best vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_q <= '0;
    end else if (state_q == S_IDLE) begin
      dist_q <= '0;
    end else if (run && !abort && cand_vld && better) begin
      dist_q <= dist_d;
    end
  end
`else
  assign better = (sad < min_sad);
`endif

  // Main FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; req is ignored while a search runs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req) state_d = S_RUN;
      S_RUN:   if (abort || scan_end || thr_hit) state_d = S_DONE;
      S_DONE:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Run counter, scan counters, enable delays and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pe_sw_q    <= 1'b0;
      pe_tb_q    <= 1'b0;
      min_sad    <= '1;
      min_mvec   <= '0;
      cand_cnt   <= '0;
      early_term <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cyc_q      <= '0;
          x_q        <= '0;
          y_q        <= '0;
          pe_sw_q    <= 1'b0;
          pe_tb_q    <= 1'b0;
          min_sad    <= '1;
          min_mvec   <= '0;
          cand_cnt   <= '0;
          early_term <= 1'b0;
          aborted    <= 1'b0;
        end
        S_RUN: begin
          cyc_q   <= cyc_q + CYC_W'(1);
          pe_sw_q <= en_addr_sw;
          pe_tb_q <= en_addr_tb;
          if (abort) begin
            aborted <= 1'b1;
          end else begin
            if (scan_act) begin
              if (y_q == XY_W'(SW_LENGTH - 1)) begin
                y_q <= '0;
                x_q <= x_q + XY_W'(1);
              end else begin
                y_q <= y_q + XY_W'(1);
              end
            end
            if (cand_vld) begin
              cand_cnt <= cand_cnt + CNT_WIDTH'(1);
              if (better) begin
                min_sad  <= sad;
                min_mvec <= {y_off, x_off};
              end
            end
            if (thr_hit) early_term <= 1'b1;
          end
        end
        S_DONE: begin
          pe_sw_q <= 1'b0;
          pe_tb_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_me_ctrl_search_unit.sv
// Bench for me_ctrl_search_unit: directed table, reset-in-run, random runs vs model.
// Small geometry: 8x8 window, 4x4 template, PE latency 3.
module tb_me_ctrl_search_unit;

  localparam int SW   = 8;
  localparam int TB   = 4;
  localparam int PL   = 3;
  localparam int SW_N = SW * SW;
  localparam int CC   = (SW - TB) / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        abort = 1'b0;
  logic        thr_en = 1'b0;
  logic [15:0] sad_thresh = '0;
  logic [15:0] sad = '0;
  logic        clr, en_addr_sw, en_addr_tb, en_pearray_sw, en_pearray_tb;
  logic [15:0] min_sad;
  logic [5:0]  min_mvec;
  logic [11:0] cand_cnt;
  logic        early_term, aborted, ack;

  me_ctrl_search_unit #(
    .SAD_WIDTH (16),
    .TB_LENGTH (TB),
    .SW_LENGTH (SW),
    .PE_LATENCY(PL),
    .CNT_WIDTH (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .abort        (abort),
    .thr_en       (thr_en),
    .sad_thresh   (sad_thresh),
    .sad          (sad),
    .clr          (clr),
    .en_addr_sw   (en_addr_sw),
    .en_addr_tb   (en_addr_tb),
    .en_pearray_sw(en_pearray_sw),
    .en_pearray_tb(en_pearray_tb),
    .min_sad      (min_sad),
    .min_mvec     (min_mvec),
    .cand_cnt     (cand_cnt),
    .early_term   (early_term),
    .aborted      (aborted),
    .ack          (ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pat;
    int          thr;
    int          thr_val;
    int          abort_at;
    int          done_cyc;
    logic [15:0] e_sad;
    logic [5:0]  e_mv;
    int          e_cnt;
    bit          e_et;
    bit          e_ab;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sad_map [SW_N];
  vec_t        vecs [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scan position index = x*SW + y (y fastest)
  task automatic fill_map(input int pat);
    for (int i = 0; i < SW_N; i++) begin
      unique case (pat)
        0, 1, 3: sad_map[i] = 16'd100;
        2:       sad_map[i] = 16'd50;
        default: sad_map[i] = 16'($urandom_range(0, 40));
      endcase
    end
    if (pat == 0) sad_map[5*SW+6] = 16'd7;
    if (pat == 1) sad_map[3*SW+3] = 16'd9;
    if (pat == 3) sad_map[3*SW+5] = 16'd1;
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference: walk run cycles, apply the search rules directly
  task automatic model(input int thr, input int thr_val,
                       input int abort_at, output vec_t v);
    int ms, mv, cnt, md;
    bit et, ab;
    int done;
    ms = 16'hFFFF; mv = 0; cnt = 0; md = 0;
    et = 0; ab = 0; done = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k == abort_at) begin
        ab = 1; done = k + 1; break;
      end
      if (k >= PL) begin
        int idx, x, y, xo, yo, s, d;
        bit take;
        idx = k - PL;
        x = idx / SW;
        y = idx % SW;
        if (x >= TB - 1 && y >= TB - 1) begin
          xo = x - (TB - 1);
          yo = y - (TB - 1);
          s = int'(sad_map[idx]);
          d = absd(xo, CC) + absd(yo, CC);
          cnt++;
          take = (s < ms);
`ifdef TIEBREAK_CENTER_EN
          if (s == ms && d < md) take = 1;
`endif
          if (take) begin
            ms = s; mv = yo * 8 + xo; md = d;
          end
          if (thr != 0 && s <= thr_val) begin
            et = 1; done = k + 1; break;
          end
        end
        if (idx == SW_N - 1) begin
          done = k + 1; break;
        end
      end
    end
    v.pat = 4; v.thr = thr; v.thr_val = thr_val;
    v.abort_at = abort_at; v.done_cyc = done;
    v.e_sad = 16'(ms); v.e_mv = 6'(mv); v.e_cnt = cnt;
    v.e_et = et; v.e_ab = ab;
  endtask

  task automatic run_search(input string nm, input vec_t v);
    int ack_early, en_bad;
    ack_early = 0;
    en_bad = 0;
    @(negedge clk);
    req = 1'b1;
    thr_en = (v.thr != 0);
    sad_thresh = 16'(v.thr_val);
    abort = 1'b0;
    @(posedge clk);
    for (int k = 0; k < v.done_cyc; k++) begin
      @(negedge clk);
      if (k >= PL && k - PL < SW_N) sad = sad_map[k-PL];
      else sad = 16'($urandom);
      abort = (k == v.abort_at);
      if (ack) ack_early++;
      if (en_addr_sw !== (k < SW_N) || en_addr_tb !== (k < TB*TB)
          || en_pearray_sw !== (k >= 1 && k <= SW_N)
          || en_pearray_tb !== (k >= 1 && k <= TB*TB)
          || clr !== 1'b0)
        en_bad++;
      @(posedge clk);
    end
    @(negedge clk);
    abort = 1'b0;
    chk({nm, ".ack_early"}, ack_early, 0);
    chk({nm, ".en_timing"}, en_bad, 0);
    chk({nm, ".ack"}, ack, 1);
    chk({nm, ".min_sad"}, min_sad, v.e_sad);
    chk({nm, ".min_mvec"}, min_mvec, v.e_mv);
    chk({nm, ".cand_cnt"}, cand_cnt, v.e_cnt);
    chk({nm, ".early_term"}, early_term, v.e_et);
    chk({nm, ".aborted"}, aborted, v.e_ab);
    chk({nm, ".done_outs"},
        {clr, en_addr_sw, en_addr_tb, en_pearray_sw, en_pearray_tb}, 0);
    req = 1'b0;
    @(negedge clk);
    chk({nm, ".ack_hold"}, ack, 0);
    chk({nm, ".idle_clr"}, clr, 1);
    @(negedge clk);
    chk({nm, ".idle_regs"}, {min_sad, cand_cnt, early_term, aborted},
        {16'hFFFF, 12'd0, 2'b00});
  endtask

  initial begin
    vec_t v;
    logic [5:0] mv_tie, mv_ab;
`ifdef TIEBREAK_CENTER_EN
    mv_tie = 6'd18;
    mv_ab  = 6'd8;
`else
    mv_tie = 6'd0;
    mv_ab  = 6'd0;
`endif
    vecs[0] = '{0, 0, 0, -1, 67, 16'd7, 6'd26, 25, 1'b0, 1'b0};
    vecs[1] = '{1, 1, 10, -1, 31, 16'd9, 6'd0, 1, 1'b1, 1'b0};
    vecs[2] = '{2, 0, 0, -1, 67, 16'd50, mv_tie, 25, 1'b0, 1'b0};
    vecs[3] = '{3, 1, 0, 32, 33, 16'd100, mv_ab, 2, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset.outs",
        {clr, en_addr_sw, en_addr_tb, en_pearray_sw, en_pearray_tb, ack},
        6'b100000);
    chk("reset.regs", {min_sad, min_mvec, cand_cnt, early_term, aborted},
        {16'hFFFF, 6'd0, 12'd0, 2'b00});
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fill_map(vecs[i].pat);
      run_search($sformatf("dir%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a run
    fill_map(0);
    @(negedge clk);
    req = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("rst_run.pre", {clr, en_addr_sw, ack}, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("rst_run.outs",
        {clr, en_addr_sw, en_addr_tb, en_pearray_sw, en_pearray_tb, ack},
        6'b100000);
    chk("rst_run.regs", {min_sad, cand_cnt}, {16'hFFFF, 12'd0});
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      int thr, tv, ab;
      fill_map(4);
      thr = int'($urandom_range(0, 1));
      tv  = int'($urandom_range(0, 6));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : -1;
      model(thr, tv, ab, v);
      run_search($sformatf("rnd%0d", r), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_ctrl_search_unit.md
Name: me_ctrl_search_unit

Overview:
- Parametrised successor control unit for the full-search motion estimation processor.
- Sequences search-window and template-block address/PE-array enables from a single run counter.
- Raster-scans the SAD stream from the PE array, tracks minimum SAD and motion vector (offset-encoded), and counts evaluated candidates.
- Adds runtime early termination on a SAD threshold and an abort input. Sits between the host req/ack interface and the address generators/PE array.

Parameters:
- SAD_WIDTH, 16, width of sad/min_sad
- TB_LENGTH, 16, template block side (pixels)
- SW_LENGTH, 64, search window side (pixels); must be > TB_LENGTH
- PE_LATENCY, 55, RUN cycles before the first scan position reaches the sad input; >= 1
- CNT_WIDTH, 12, width of cand_cnt; must hold (SW_LENGTH-TB_LENGTH+1)^2
- MV_WIDTH, derived clog2(SW_LENGTH-TB_LENGTH+1), per-axis vector width (not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  1  start request, four-phase with ack
- abort  in  1  terminate search immediately
- thr_en  in  1  enable early termination
- sad_thresh  in  SAD_WIDTH  early-termination threshold
- sad  in  SAD_WIDTH  SAD of current scan position from PE array
- clr  out  1  PE-array/accumulator clear, high in IDLE
- en_addr_sw  out  1  search-window address generator enable
- en_addr_tb  out  1  template-block address generator enable
- en_pearray_sw  out  1  PE-array search-window load enable
- en_pearray_tb  out  1  PE-array template load enable
- min_sad  out  SAD_WIDTH  best SAD found
- min_mvec  out  2*MV_WIDTH  {y_off, x_off} of best SAD
- cand_cnt  out  CNT_WIDTH  candidates evaluated
- early_term  out  1  search ended by threshold
- aborted  out  1  search ended by abort
- ack  out  1  result valid, high in DONE

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high. Reset forces IDLE and all registers as in IDLE: min_sad all-ones, min_mvec 0, cand_cnt 0, flags 0, all enables 0, clr 1, ack 0.
- Main FSM:
  - IDLE: req=1 -> RUN next cycle. Holds IDLE values; clears cyc and the scan counters.
  - RUN: exits to DONE on scan end, early termination or abort. req changes are ignored.
  - DONE: ack=1; outputs hold. req=0 -> IDLE next cycle.
- cyc: counts RUN cycles, 0 on the first RUN cycle; width clog2(PE_LATENCY+SW_LENGTH^2+1).
- en_addr_sw = RUN && cyc < SW_LENGTH^2.
- en_addr_tb = RUN && cyc < TB_LENGTH^2.
- en_pearray_sw and en_pearray_tb: registered one-cycle delays of en_addr_sw and en_addr_tb; forced 0 outside RUN.
- Scan: while RUN and cyc >= PE_LATENCY, counters (x, y) step once per cycle from (0,0), y fastest, wrap at SW_LENGTH-1. Scan ends on the cycle at (SW_LENGTH-1, SW_LENGTH-1); DONE follows next cycle.
- Candidate valid when x >= TB_LENGTH-1 and y >= TB_LENGTH-1. Offsets: x_off = x-(TB_LENGTH-1), y_off = y-(TB_LENGTH-1).
- On a valid cycle:
  - cand_cnt increments.
  - If sad < min_sad (strict), load min_sad and min_mvec. Ties keep the earlier candidate.
- Early termination: valid && thr_en && sad <= sad_thresh -> normal min update, early_term=1, DONE next cycle.
- Abort: abort=1 in RUN -> DONE next cycle, aborted=1. That cycle's candidate is discarded (no min update, no cand_cnt increment). Abort has priority over early termination and scan end in the same cycle.
- abort outside RUN has no effect.
- Width rules: cand_cnt and the counters never wrap within a legal run. Comparisons are unsigned.

Optional Feature:
- Macro: TIEBREAK_CENTER_EN.
- Defined: when sad == min_sad on a valid cycle, min_mvec and min_sad are replaced if |x_off-C|+|y_off-C| is strictly smaller than the stored vector's distance. C = (SW_LENGTH-TB_LENGTH)/2. Requires one registered distance of MV_WIDTH+1 bits, cleared in IDLE.
- Undefined: strict-less rule only; first candidate wins ties.

Test Plan:
- Reset while RUN with SW_LENGTH=8, TB_LENGTH=4, PE_LATENCY=3 -> immediately clr=1, all enables 0, min_sad=FFFF, cand_cnt=0, ack=0.
- Same params, sad = 100 everywhere except 7 at scan (x=5,y=6) -> ack high at RUN cycle 67; min_sad=7, min_mvec={3'd3,3'd2}, cand_cnt=25; ack drops one cycle after req falls.
- Enable timing, same params -> en_addr_sw high cyc 0..63, en_addr_tb high cyc 0..15, pearray enables one cycle later.
- thr_en=1, sad_thresh=10, sad=9 at first candidate (3,3) -> DONE next cycle, early_term=1, min_sad=9, min_mvec=0, cand_cnt=1.
- abort pulsed on same cycle as a valid sad=1 -> aborted=1, min_sad unchanged, cand_cnt unchanged, DONE next cycle.
- All sad equal 50 -> min_mvec=0 without TIEBREAK_CENTER_EN; {3'd2,3'd2} with it.
